// File: rtl/compare_qualifier.sv
// Glitch filter after the magnitude comparator: qualifies LT/EQ/GT after QUAL_N agreeing samples.
// Optional COMPARE_ERR_CHECK_EN: discard non-one-hot samples and flag them on sticky err.
module compare_qualifier #(
  parameter int QUAL_N = 4,
  parameter int EVT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_lt,
  input  logic             in_eq,
  input  logic             in_gt,
  input  logic             clr,
  output logic             q_lt,
  output logic             q_eq,
  output logic             q_gt,
  output logic             q_valid,
  output logic             change_p,
  output logic [EVT_W-1:0] evt_cnt,
  output logic             err
);

  typedef enum logic [1:0] {
    C_NONE, C_LT, C_EQ, C_GT
  } code_e;

  typedef enum logic [1:0] {
    UNQUAL, QUAL_LT, QUAL_EQ, QUAL_GT
  } state_e;

  localparam logic [7:0] QN = 8'(QUAL_N);

  code_e      code;
  logic       samp_ok;
  code_e      cand_q, cand_d;
  logic [7:0] run_q, run_d;
  state_e     state_q, state_d;
  code_e      rel_q;
  logic       qualify;

  logic             q_lt_q, q_lt_d;
  logic             q_eq_q, q_eq_d;
  logic             q_gt_q, q_gt_d;
  logic             q_valid_q, q_valid_d;
  logic             change_q, change_d;
  logic [EVT_W-1:0] evt_q, evt_d;

`ifdef COMPARE_ERR_CHECK_EN
  logic samp_bad;
  logic err_q, err_d;

  always_comb begin
    code = C_NONE;
    case ({in_lt, in_eq, in_gt})
      3'b100:  code = C_LT;
      3'b010:  code = C_EQ;
      3'b001:  code = C_GT;
      default: code = C_NONE;
    endcase
    samp_ok  = in_valid && (code != C_NONE);
    samp_bad = in_valid && (code == C_NONE);
  end

  always_comb begin
    err_d = err_q | samp_bad;
    if (clr) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  // Non-one-hot inputs resolve by priority GT > EQ > LT
  always_comb begin
    code = C_NONE;
    priority case (1'b1)
      in_gt:   code = C_GT;
      in_eq:   code = C_EQ;
      in_lt:   code = C_LT;
      default: code = C_NONE;
    endcase
    samp_ok = in_valid && (code != C_NONE);
  end

  assign err = 1'b0;
`endif

  always_comb begin
    cand_d = cand_q;
    run_d  = run_q;
    if (clr) begin
      cand_d = C_NONE;
      run_d  = '0;
    end else if (samp_ok) begin
      if (code == cand_q) begin
        run_d = (run_q >= QN) ? QN : run_q + 8'd1;
      end else begin
        cand_d = code;
        run_d  = 8'd1;
      end
    end
  end

  always_comb begin
    rel_q = C_NONE;
    unique case (state_q)
      QUAL_LT: rel_q = C_LT;
      QUAL_EQ: rel_q = C_EQ;
      QUAL_GT: rel_q = C_GT;
      default: rel_q = C_NONE;
    endcase
  end

  assign qualify = !clr && samp_ok &&
                   (run_d == QN) &&
                   (cand_d != rel_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNQUAL;
      cand_q  <= C_NONE;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = UNQUAL;
    end else if (qualify) begin
      unique case (cand_d)
        C_LT:    state_d = QUAL_LT;
        C_EQ:    state_d = QUAL_EQ;
        C_GT:    state_d = QUAL_GT;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    q_lt_d    = (state_d == QUAL_LT);
    q_eq_d    = (state_d == QUAL_EQ);
    q_gt_d    = (state_d == QUAL_GT);
    q_valid_d = (state_d != UNQUAL);
    change_d  = qualify;
    evt_d     = evt_q + EVT_W'(qualify);
    if (clr) evt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_lt_q    <= 1'b0;
      q_eq_q    <= 1'b0;
      q_gt_q    <= 1'b0;
      q_valid_q <= 1'b0;
      change_q  <= 1'b0;
      evt_q     <= '0;
    end else begin
      q_lt_q    <= q_lt_d;
      q_eq_q    <= q_eq_d;
      q_gt_q    <= q_gt_d;
      q_valid_q <= q_valid_d;
      change_q  <= change_d;
      evt_q     <= evt_d;
    end
  end

  assign q_lt     = q_lt_q;
  assign q_eq     = q_eq_q;
  assign q_gt     = q_gt_q;
  assign q_valid  = q_valid_q;
  assign change_p = change_q;
  assign evt_cnt  = evt_q;

endmodule

// File: tb/tb_compare_qualifier.sv
// Bench for compare_qualifier: QUAL_N=4 and QUAL_N=1 instances on shared stimulus,
// checked every cycle against a sample-history model plus literal spot checks.
module tb_compare_qualifier;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_lt = 1'b0;
  logic in_eq = 1'b0;
  logic in_gt = 1'b0;
  logic clr = 1'b0;

  logic q_lt4, q_eq4, q_gt4, q_valid4, chg4, err4;
  logic q_lt1, q_eq1, q_gt1, q_valid1, chg1, err1;
  logic [3:0] evt4, evt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  compare_qualifier #(.QUAL_N(4), .EVT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_lt(in_lt), .in_eq(in_eq), .in_gt(in_gt), .clr(clr),
    .q_lt(q_lt4), .q_eq(q_eq4), .q_gt(q_gt4),
    .q_valid(q_valid4), .change_p(chg4),
    .evt_cnt(evt4), .err(err4)
  );

  compare_qualifier #(.QUAL_N(1), .EVT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_lt(in_lt), .in_eq(in_eq), .in_gt(in_gt), .clr(clr),
    .q_lt(q_lt1), .q_eq(q_eq1), .q_gt(q_gt1),
    .q_valid(q_valid1), .change_p(chg1),
    .evt_cnt(evt1), .err(err1)
  );

  // Model: relation is the code shared by the last qn legal samples (1=LT,2=EQ,3=GT)
  int h[2][4];
  int m_rel[2] = '{0, 0};
  int m_qv[2]  = '{0, 0};
  int m_chg[2] = '{0, 0};
  int m_evt[2] = '{0, 0};
  int m_err[2] = '{0, 0};

  task automatic mreset(input int k);
    for (int i = 0; i < 4; i++) h[k][i] = 0;
    m_rel[k] = 0;
    m_qv[k]  = 0;
    m_chg[k] = 0;
    m_evt[k] = 0;
    m_err[k] = 0;
  endtask

  task automatic mstep(input int k, input int qn);
    int code;
    int hot;
    bit all;
    code = 0;
    hot = int'(in_lt) + int'(in_eq) + int'(in_gt);
    m_chg[k] = 0;
    if (in_valid) begin
`ifdef COMPARE_ERR_CHECK_EN
      if (hot == 1) code = in_lt ? 1 : (in_eq ? 2 : 3);
      else m_err[k] = 1;
`else
      if (in_gt) code = 3;
      else if (in_eq) code = 2;
      else if (in_lt) code = 1;
`endif
    end
    if (code != 0) begin
      for (int i = 3; i > 0; i--) h[k][i] = h[k][i-1];
      h[k][0] = code;
      all = 1'b1;
      for (int i = 0; i < qn; i++)
        if (h[k][i] != code) all = 1'b0;
      if (all && code != m_rel[k]) begin
        m_rel[k] = code;
        m_qv[k]  = 1;
        m_chg[k] = 1;
        m_evt[k] = (m_evt[k] + 1) % 16;
      end
    end
  endtask

  initial begin
    mreset(0);
    mreset(1);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mreset(0);
      mreset(1);
    end else if (clr) begin
      mreset(0);
      mreset(1);
    end else begin
      mstep(0, 4);
      mstep(1, 1);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m4.q_lt", int'(q_lt4), int'(m_rel[0] == 1));
      chk("m4.q_eq", int'(q_eq4), int'(m_rel[0] == 2));
      chk("m4.q_gt", int'(q_gt4), int'(m_rel[0] == 3));
      chk("m4.q_valid", int'(q_valid4), m_qv[0]);
      chk("m4.change_p", int'(chg4), m_chg[0]);
      chk("m4.evt_cnt", int'(evt4), m_evt[0]);
      chk("m4.err", int'(err4), m_err[0]);
      chk("m1.q_lt", int'(q_lt1), int'(m_rel[1] == 1));
      chk("m1.q_eq", int'(q_eq1), int'(m_rel[1] == 2));
      chk("m1.q_gt", int'(q_gt1), int'(m_rel[1] == 3));
      chk("m1.q_valid", int'(q_valid1), m_qv[1]);
      chk("m1.change_p", int'(chg1), m_chg[1]);
      chk("m1.evt_cnt", int'(evt1), m_evt[1]);
      chk("m1.err", int'(err1), m_err[1]);
    end
  end

  task automatic step(input logic v, input logic l,
                      input logic e, input logic g,
                      input logic c = 1'b0);
    in_valid = v;
    in_lt = l;
    in_eq = e;
    in_gt = g;
    clr = c;
    @(negedge clk);
  endtask

  task automatic gt();   step(1, 0, 0, 1); endtask
  task automatic lt();   step(1, 1, 0, 0); endtask
  task automatic eq();   step(1, 0, 1, 0); endtask
  task automatic idle(); step(0, 0, 0, 0); endtask
  task automatic doclr(); step(0, 0, 0, 0, 1); endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle();
    chk("reset q_valid", int'(q_valid4), 0);
    chk("reset evt", int'(evt4), 0);
    chk("reset q_gt", int'(q_gt4), 0);

    // four GT samples qualify
    repeat (3) gt();
    chk("3gt no qual", int'(q_valid4), 0);
    chk("1gt qual n1", int'(evt1), 1);
    gt();
    chk("4gt q_gt", int'(q_gt4), 1);
    chk("4gt chg", int'(chg4), 1);
    chk("4gt evt", int'(evt4), 1);
    idle();
    chk("chg one cycle", int'(chg4), 0);

    // interrupted LT runs do not qualify
    repeat (3) lt();
    eq();
    repeat (3) lt();
    chk("broken lt hold", int'(q_gt4), 1);
    chk("broken lt evt", int'(evt4), 1);
    lt();
    chk("4lt q_lt", int'(q_lt4), 1);
    chk("4lt chg", int'(chg4), 1);
    chk("4lt evt", int'(evt4), 2);
    chk("n1 evt", int'(evt1), 4);

    // gaps do not break a run; zero-hot sample in a gap
    gt();
    repeat (5) idle();
    gt();
    step(1, 0, 0, 0);
    gt();
    chk("gap 3gt hold", int'(q_lt4), 1);
    gt();
    chk("gap 4gt q_gt", int'(q_gt4), 1);
    chk("gap evt", int'(evt4), 3);
    doclr();

    // counter wrap at 2^4
    chk("clr evt", int'(evt4), 0);
    for (int i = 0; i < 16; i++) begin
      repeat (4) begin
        if (i % 2 == 0) lt();
        else gt();
      end
      if (i == 14) chk("evt 15", int'(evt4), 15);
    end
    chk("wrap evt4", int'(evt4), 0);
    chk("wrap evt1", int'(evt1), 0);
    chk("wrap q_gt", int'(q_gt4), 1);

    // clr beats a simultaneous sample
    step(1, 0, 0, 1, 1);
    chk("clr+v q_valid4", int'(q_valid4), 0);
    chk("clr+v q_valid1", int'(q_valid1), 0);
    chk("clr+v evt1", int'(evt1), 0);
    repeat (3) gt();
    chk("clr+v discard", int'(q_valid4), 0);
    gt();
    chk("clr+v 4gt", int'(q_gt4), 1);
    doclr();

    // non-one-hot sample
    repeat (3) gt();
    step(1, 1, 0, 1);
`ifdef COMPARE_ERR_CHECK_EN
    chk("bad err", int'(err4), 1);
    chk("bad no qual", int'(q_valid4), 0);
    gt();
    chk("bad run kept", int'(q_gt4), 1);
`else
    chk("bad err0", int'(err4), 0);
    chk("bad as gt", int'(q_gt4), 1);
`endif
    doclr();
    chk("clr err", int'(err4), 0);

    // async reset mid-run
    repeat (3) gt();
    #2 rst_n = 1'b0;
    #1;
    chk("arst q_gt1", int'(q_gt1), 0);
    chk("arst evt1", int'(evt1), 0);
    chk("arst q_valid1", int'(q_valid1), 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) gt();
    chk("rst 3gt", int'(q_valid4), 0);
    gt();
    chk("rst 4gt", int'(q_gt4), 1);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
